// File: rtl/launch_ctrl_if.sv
// Bus between the keyboard/tank/projectile side and the firing controller.
// master: the environment (drives keycode, tank positions, boomed).
// slave : launch_ctrl (drives launch, launch position, angle, power, player, state_o).
interface launch_ctrl_if;
    logic [7:0] keycode;
    logic [9:0] tank0X;
    logic [9:0] tank0Y;
    logic [9:0] tank1X;
    logic [9:0] tank1Y;
    logic       boomed;
    logic       launch;
    logic [9:0] launchX;
    logic [9:0] launchY;
    logic [3:0] angle;
    logic [2:0] power;
    logic       player;
    logic [2:0] state_o;

    modport master (
        output keycode, tank0X, tank0Y, tank1X, tank1Y, boomed,
        input  launch, launchX, launchY, angle, power, player, state_o
    );

    modport slave (
        input  keycode, tank0X, tank0Y, tank1X, tank1Y, boomed,
        output launch, launchX, launchY, angle, power, player, state_o
    );
endinterface

// File: rtl/launch_ctrl.sv
// launch_ctrl: per-turn firing controller upstream of the projectile block.
// Keyboard keycodes set per-player angle, a hold-to-charge meter sets power,
// release fires a one-frame launch pulse, then the block waits for the
// explosion, settles and hands the turn to the other player.
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   frame_clk vsync-rate strobe, sampled as data through a synchroniser
//   bus       launch_ctrl_if.slave (keycode, tank positions, boomed in;
//             launch, launchX/Y, angle, power, player, state_o out)
// Optional feature: define POWER_PINGPONG_EN to make power bounce 0..7..0
// while charging instead of saturating at 7.
module launch_ctrl #(
    parameter int unsigned ANGLE_REPEAT   = 4,
    parameter int unsigned CHARGE_FRAMES  = 6,
    parameter int unsigned SETTLE_FRAMES  = 30,
    parameter int unsigned FLIGHT_TIMEOUT = 255,
    parameter logic [7:0]  KEY_LEFT       = 8'h04,
    parameter logic [7:0]  KEY_RIGHT      = 8'h07,
    parameter logic [7:0]  KEY_FIRE       = 8'h2C
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         frame_clk,
    launch_ctrl_if.slave bus
);
    localparam int unsigned CW = 8;
    localparam int unsigned AW = 4;
    localparam int unsigned PW = 3;

    // Zero-valued parameters behave as 1
    localparam logic [CW-1:0] AR = (ANGLE_REPEAT   == 0) ? CW'(1) : CW'(ANGLE_REPEAT);
    localparam logic [CW-1:0] CF = (CHARGE_FRAMES  == 0) ? CW'(1) : CW'(CHARGE_FRAMES);
    localparam logic [CW-1:0] SF = (SETTLE_FRAMES  == 0) ? CW'(1) : CW'(SETTLE_FRAMES);
    localparam logic [CW-1:0] FT = (FLIGHT_TIMEOUT == 0) ? CW'(1) : CW'(FLIGHT_TIMEOUT);

    localparam logic [AW-1:0] ANG_MAX  = AW'(8);
    localparam logic [AW-1:0] ANG0_RST = AW'(6);
    localparam logic [AW-1:0] ANG1_RST = AW'(2);
    localparam logic [PW-1:0] PWR_MAX  = PW'(7);

    typedef enum logic [2:0] {
        S_AIM    = 3'd0,
        S_CHARGE = 3'd1,
        S_FIRE   = 3'd2,
        S_FLIGHT = 3'd3,
        S_SETTLE = 3'd4
    } state_t;

    state_t        state_q, state_n;
    logic [2:0]    fsync_q;
    logic          tick_q;
    logic [CW-1:0] rpt_q, rpt_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic [AW-1:0] ang0_q, ang0_n, ang1_q, ang1_n, angle_q, angle_n;
    logic [PW-1:0] power_q, power_n, pwr_step;
    logic          player_q, player_n;
    logic          launch_q, launch_n;
    logic          armed_q, armed_n;
    logic [9:0]    lx_q, lx_n, ly_q, ly_n;
    logic [CW:0]   cnt_inc, rpt_inc;
    logic [AW-1:0] cur_ang, ang_up, ang_dn;
    logic          key_left, key_right, key_fire;
`ifdef POWER_PINGPONG_EN
    logic          dir_q, dir_n, dir_step;
`endif

    assign key_left  = (bus.keycode == KEY_LEFT);
    assign key_right = (bus.keycode == KEY_RIGHT);
    assign key_fire  = (bus.keycode == KEY_FIRE);

    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    assign rpt_inc = {1'b0, rpt_q} + (CW+1)'(1);

    // Clamped angle neighbours of the current player's stored angle
    assign cur_ang = player_q ? ang1_q : ang0_q;
    assign ang_up  = (cur_ang >= ANG_MAX) ? ANG_MAX : cur_ang + AW'(1);
    assign ang_dn  = (cur_ang == AW'(0)) ? AW'(0) :
                     (cur_ang > ANG_MAX) ? ANG_MAX : cur_ang - AW'(1);

    // Next power value on a charge step
`ifdef POWER_PINGPONG_EN
    always_comb begin
        pwr_step = power_q;
        dir_step = dir_q;
        if (dir_q) begin
            if (power_q == PWR_MAX) begin
                pwr_step = power_q - PW'(1);
                dir_step = 1'b0;
            end else begin
                pwr_step = power_q + PW'(1);
            end
        end else begin
            if (power_q == PW'(0)) begin
                pwr_step = PW'(1);
                dir_step = 1'b1;
            end else begin
                pwr_step = power_q - PW'(1);
            end
        end
    end
`else
    assign pwr_step = (power_q == PWR_MAX) ? PWR_MAX : power_q + PW'(1);
`endif

    // frame_clk synchroniser plus edge register; tick_q lags a rise by 3 clk
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fsync_q <= 3'b000;
            tick_q  <= 1'b0;
        end else begin
            fsync_q <= {fsync_q[1:0], frame_clk};
            tick_q  <= fsync_q[1] & ~fsync_q[2];
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_AIM;
        else          state_q <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_AIM:    if (key_fire) state_n = S_CHARGE;
            S_CHARGE: if (!key_fire) state_n = S_FIRE;
            S_FIRE:   if (tick_q && launch_q) state_n = S_FLIGHT;
            S_FLIGHT: begin
                if (armed_q && bus.boomed)                 state_n = S_SETTLE;
                else if (tick_q && cnt_inc >= {1'b0, FT})  state_n = S_SETTLE;
            end
            S_SETTLE: if (tick_q && cnt_inc == {1'b0, SF}) state_n = S_AIM;
            default:  state_n = S_AIM;
        endcase
    end

    // Datapath next values
    always_comb begin
        rpt_n    = rpt_q;
        cnt_n    = cnt_q;
        ang0_n   = ang0_q;
        ang1_n   = ang1_q;
        power_n  = power_q;
        player_n = player_q;
        launch_n = launch_q;
        armed_n  = armed_q;
        lx_n     = lx_q;
        ly_n     = ly_q;
`ifdef POWER_PINGPONG_EN
        dir_n    = dir_q;
`endif
        case (state_q)
            S_AIM: begin
                if (key_left || key_right) begin
                    if (tick_q) begin
                        // Step on the first tick of a hold, then every AR ticks
                        if (rpt_q == CW'(0)) begin
                            if (player_q) ang1_n = key_right ? ang_up : ang_dn;
                            else          ang0_n = key_right ? ang_up : ang_dn;
                        end
                        rpt_n = (rpt_inc >= {1'b0, AR}) ? CW'(0) : rpt_inc[CW-1:0];
                    end
                end else begin
                    rpt_n = CW'(0);
                end
                if (key_fire) begin
                    power_n = PW'(0);
                    cnt_n   = CW'(0);
`ifdef POWER_PINGPONG_EN
                    dir_n   = 1'b1;
`endif
                end
            end
            S_CHARGE: begin
                if (!key_fire) begin
                    lx_n  = player_q ? bus.tank1X : bus.tank0X;
                    ly_n  = player_q ? bus.tank1Y : bus.tank0Y;
                    cnt_n = CW'(0);
                end else if (tick_q) begin
                    if (cnt_inc >= {1'b0, CF}) begin
                        cnt_n   = CW'(0);
                        power_n = pwr_step;
`ifdef POWER_PINGPONG_EN
                        dir_n   = dir_step;
`endif
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end
            S_FIRE: begin
                // First tick raises launch, second drops it
                if (tick_q) begin
                    launch_n = ~launch_q;
                    if (launch_q) begin
                        cnt_n   = CW'(0);
                        armed_n = 1'b0;
                    end
                end
            end
            S_FLIGHT: begin
                if (!armed_q && !bus.boomed) armed_n = 1'b1;
                if (state_n != S_FLIGHT) cnt_n = CW'(0);
                else if (tick_q)         cnt_n = cnt_inc[CW-1:0];
            end
            S_SETTLE: begin
                if (tick_q) begin
                    if (cnt_inc >= {1'b0, SF}) begin
                        cnt_n    = CW'(0);
                        rpt_n    = CW'(0);
                        player_n = ~player_q;
                        power_n  = PW'(0);
                    end else begin
                        cnt_n = cnt_inc[CW-1:0];
                    end
                end
            end
            default: begin
                cnt_n    = CW'(0);
                rpt_n    = CW'(0);
                launch_n = 1'b0;
                armed_n  = 1'b0;
            end
        endcase
        angle_n = player_n ? ang1_n : ang0_n;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_q    <= CW'(0);
            cnt_q    <= CW'(0);
            ang0_q   <= ANG0_RST;
            ang1_q   <= ANG1_RST;
            angle_q  <= ANG0_RST;
            power_q  <= PW'(0);
            player_q <= 1'b0;
            launch_q <= 1'b0;
            armed_q  <= 1'b0;
            lx_q     <= 10'd0;
            ly_q     <= 10'd0;
`ifdef POWER_PINGPONG_EN
            dir_q    <= 1'b1;
`endif
        end else begin
            rpt_q    <= rpt_n;
            cnt_q    <= cnt_n;
            ang0_q   <= ang0_n;
            ang1_q   <= ang1_n;
            angle_q  <= angle_n;
            power_q  <= power_n;
            player_q <= player_n;
            launch_q <= launch_n;
            armed_q  <= armed_n;
            lx_q     <= lx_n;
            ly_q     <= ly_n;
`ifdef POWER_PINGPONG_EN
            dir_q    <= dir_n;
`endif
        end
    end

    assign bus.launch  = launch_q;
    assign bus.launchX = lx_q;
    assign bus.launchY = ly_q;
    assign bus.angle   = angle_q;
    assign bus.power   = power_q;
    assign bus.player  = player_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_launch_ctrl.sv
// Directed bench for launch_ctrl: aiming with clamps, charge and release,
// one-frame launch pulse, flight/settle handover, timeout and async reset.
`timescale 1ns/1ps
module tb_launch_ctrl;
    localparam logic [7:0] K_LEFT  = 8'h04;
    localparam logic [7:0] K_RIGHT = 8'h07;
    localparam logic [7:0] K_FIRE  = 8'h2C;
`ifdef POWER_PINGPONG_EN
    localparam int P48  = 6;
    localparam int P100 = 2;
`else
    localparam int P48  = 7;
    localparam int P100 = 7;
`endif

    logic clk;
    logic reset_n;
    logic frame_clk;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rises_hi = 0;
    int   rises0;

    launch_ctrl_if bus();

    launch_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .frame_clk (frame_clk),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 200 ns frame period, edges offset from clk edges
    initial begin
        frame_clk = 1'b0;
        #3;
        forever #100 frame_clk = ~frame_clk;
    end

    always @(posedge frame_clk) if (bus.launch) rises_hi++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait n frame rises, then far enough for the resulting tick to be applied
    task automatic ticks(input int n);
        repeat (n) @(posedge frame_clk);
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        bus.keycode = 8'h00;
        bus.tank0X  = 10'd100;
        bus.tank0Y  = 10'd200;
        bus.tank1X  = 10'd500;
        bus.tank1Y  = 10'd300;
        bus.boomed  = 1'b1;
        #42;
        check("rst_state",  32'(bus.state_o), 0);
        check("rst_angle",  32'(bus.angle), 6);
        check("rst_power",  32'(bus.power), 0);
        check("rst_launch", 32'(bus.launch), 0);
        check("rst_player", 32'(bus.player), 0);
        check("rst_lx",     32'(bus.launchX), 0);
        #8 reset_n = 1'b1;

        // Angle right: 6,7,8 then clamp
        bus.keycode = K_RIGHT;
        ticks(1);  check("right_t1",  32'(bus.angle), 7);
        ticks(4);  check("right_t5",  32'(bus.angle), 8);
        ticks(15); check("right_t20", 32'(bus.angle), 8);

        // Angle left down to 0 and clamp
        bus.keycode = K_LEFT;
        ticks(1);  check("left_t1",  32'(bus.angle), 7);
        ticks(27); check("left_t28", 32'(bus.angle), 1);
        ticks(12); check("left_t40", 32'(bus.angle), 0);

        // Charge 20 ticks -> power 3
        bus.keycode = K_FIRE;
        clks(3);
        check("chg_state", 32'(bus.state_o), 1);
        check("chg_pwr0",  32'(bus.power), 0);
        ticks(17); check("chg_t17", 32'(bus.power), 2);
        ticks(3);  check("chg_t20", 32'(bus.power), 3);

        // Release -> FIRE with latched position, one-frame launch
        bus.keycode = 8'h00;
        clks(3);
        check("fire_state",  32'(bus.state_o), 2);
        check("fire_lx",     32'(bus.launchX), 100);
        check("fire_ly",     32'(bus.launchY), 200);
        check("fire_launch0", 32'(bus.launch), 0);
        rises0 = rises_hi;
        ticks(1);
        check("fire_launch1", 32'(bus.launch), 1);
        check("fire_pwr",     32'(bus.power), 3);
        ticks(1);
        check("fire_launch2", 32'(bus.launch), 0);
        check("flight_state", 32'(bus.state_o), 3);
        check("launch_rises", 32'(rises_hi - rises0), 1);

        // Arm then explode -> SETTLE, 30 ticks -> player 1
        bus.boomed = 1'b0;
        clks(3);   check("flt_armed", 32'(bus.state_o), 3);
        ticks(3);
        bus.boomed = 1'b1;
        clks(3);   check("settle_state", 32'(bus.state_o), 4);
        ticks(29); check("settle_t29",   32'(bus.state_o), 4);
        check("settle_t29_pl", 32'(bus.player), 0);
        ticks(1);
        check("turn_state",  32'(bus.state_o), 0);
        check("turn_player", 32'(bus.player), 1);
        check("turn_angle",  32'(bus.angle), 2);
        check("turn_power",  32'(bus.power), 0);

        // Long charge for player 1
        bus.keycode = K_FIRE;
        clks(3);
        ticks(48); check("chg_t48",  32'(bus.power), P48);
        ticks(52); check("chg_t100", 32'(bus.power), P100);
        bus.keycode = 8'h00;
        clks(3);
        check("fire1_lx", 32'(bus.launchX), 500);
        check("fire1_ly", 32'(bus.launchY), 300);
        ticks(2);
        check("flight1_state", 32'(bus.state_o), 3);

        // boomed stuck high -> timeout; keys ignored meanwhile
        bus.keycode = K_RIGHT;
        ticks(254);
        check("tmo_t254",   32'(bus.state_o), 3);
        check("tmo_angle",  32'(bus.angle), 2);
        ticks(1);
        check("tmo_t255",   32'(bus.state_o), 4);
        ticks(29);
        check("settle1_t29", 32'(bus.state_o), 4);
        check("settle1_ang", 32'(bus.angle), 2);
        ticks(1);
        check("turn1_state",  32'(bus.state_o), 0);
        check("turn1_player", 32'(bus.player), 0);
        check("turn1_angle",  32'(bus.angle), 0);
        ticks(1);
        check("held_key_aim", 32'(bus.angle), 1);

        // Async reset while launch is high
        bus.keycode = K_FIRE;
        clks(3);
        check("rf_charge", 32'(bus.state_o), 1);
        bus.keycode = 8'h00;
        clks(3);
        check("rf_fire", 32'(bus.state_o), 2);
        ticks(1);
        check("rf_launch_hi", 32'(bus.launch), 1);
        #2 reset_n = 1'b0;
        #1;
        check("rf_launch", 32'(bus.launch), 0);
        check("rf_state",  32'(bus.state_o), 0);
        check("rf_player", 32'(bus.player), 0);
        check("rf_angle",  32'(bus.angle), 6);
        #20 reset_n = 1'b1;
        clks(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
